// File: rtl/top_level_pkg.sv
// Shared definitions for the message-encryption engine: FSM states,
// memory map constants and the per-byte cipher/parity helper.
package top_level_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_INIT,
    ENC,
    DONE
  } state_t;

  localparam logic [7:0] MSG_BASE   = 8'd0;
  localparam logic [7:0] PRE_ADDR   = 8'd61;
  localparam logic [7:0] TAP_ADDR   = 8'd62;
  localparam logic [7:0] SEED_ADDR  = 8'd63;
  localparam logic [7:0] OUT_BASE   = 8'd64;
  localparam int         NUM_BYTES  = 64;
  localparam logic [7:0] MSG_MAX    = 8'd61;
  localparam logic [7:0] ASCII_BIAS = 8'h20;

  // XOR the 7-bit payload with the keystream, then tag bit 7 with its parity.
  function automatic logic [7:0] enc_byte(input logic [6:0] p, input logic [6:0] s);
    logic [6:0] c;
    c = p ^ s;
    return {^c, c};
  endfunction

endpackage

// File: rtl/top_level_if.sv
// Start/Ack handshake between a controller (master) and the engine (slave).
interface top_level_if;
  logic Start;
  logic Ack;

  modport master (output Start, input Ack);
  modport slave  (input Start, output Ack);
endinterface

// File: rtl/top_level_data_mem.sv
// 256x8 data memory: combinational read, synchronous write, never reset.
module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] Core [0:255];

  always @(posedge clk) begin
    if (we) Core[waddr] <= wdata;
  end

  assign rdata = Core[raddr];

endmodule

// File: rtl/top_level.sv
// Encryption engine: loads config from memory, then writes 64 LFSR-enciphered,
// parity-tagged bytes to the upper half of the memory and raises Ack.
module top_level
  import top_level_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  top_level_if.slave  ctl
);

  state_t     state;
  logic [5:0] idx;
  logic [6:0] lfsr;
  logic [7:0] pre;
  logic [6:0] taps;
  logic       ack;

  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] msg_off;
  logic       msg_valid;
  logic [6:0] plain;

  data_mem DM1 (
    .clk   (Clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Message byte i-pre is in range only once the preamble is over and before the padding ends.
  always_comb begin
    msg_off   = {2'b00, idx} - pre;
    msg_valid = ({2'b00, idx} >= pre) && (msg_off <= (MSG_MAX - 8'd1));
    case (state)
      LD_PRE:  rd_addr = PRE_ADDR;
      LD_TAP:  rd_addr = TAP_ADDR;
      LD_INIT: rd_addr = SEED_ADDR;
      default: rd_addr = MSG_BASE + msg_off;
    endcase
    plain   = msg_valid ? (rd_data[6:0] - ASCII_BIAS[6:0]) : 7'd0;
    wr_en   = (state == ENC) && !ctl.Start;
    wr_addr = OUT_BASE + {2'b00, idx};
    wr_data = enc_byte(plain, lfsr);
  end

  // Abort via Start=1 outranks every other transition, including the last ENC step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      idx   <= '0;
      lfsr  <= '0;
      pre   <= '0;
      taps  <= '0;
    end else if (state != IDLE && ctl.Start) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ctl.Start) state <= LD_PRE;
        end
        LD_PRE: begin
          pre   <= rd_data;
          state <= LD_TAP;
        end
        LD_TAP: begin
          taps  <= rd_data[6:0];
          state <= LD_INIT;
        end
        LD_INIT: begin
          lfsr  <= rd_data[6:0];
          idx   <= '0;
          state <= ENC;
        end
        ENC: begin
          lfsr <= {lfsr[5:0], ^(lfsr & taps)};
          idx  <= idx + 6'd1;
          if (idx == 6'(NUM_BYTES - 1)) begin
            state <= DONE;
            ack   <= 1'b1;
          end
        end
        DONE: begin
          ack <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.Ack = ack;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table vectors, hand-written corner
// sequences and a randomized tap sweep against a behavioural cipher model.
module tb_top_level;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  top_level_if ctl ();

  top_level dut (
    .Clk   (clk),
    .Reset (rst_n),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] msg [0:60];
  logic [7:0] cfg_pre;
  logic [6:0] cfg_taps;
  logic [6:0] cfg_seed;
  logic [7:0] expect_out [0:63];

  typedef struct {
    int         kind;
    logic [7:0] pre;
    logic [6:0] taps;
    logic [6:0] seed;
    int         idx;
    logic [7:0] want;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Message kinds: 0 = all spaces, 1 = "A" then spaces, 2 = random printable ASCII.
  task automatic apply_stimulus(input int kind, input logic [7:0] pre, input logic [6:0] taps,
                                input logic [6:0] seed, input logic [7:0] fill_out);
    for (int k = 0; k <= 60; k++) begin
      if (kind == 2) msg[k] = 8'($urandom_range(32, 126));
      else           msg[k] = 8'h20;
    end
    if (kind == 1) msg[0] = 8'h41;
    cfg_pre  = pre;
    cfg_taps = taps;
    cfg_seed = seed;
    for (int k = 0; k <= 60; k++) dut.DM1.Core[k] = msg[k];
    dut.DM1.Core[61] = cfg_pre;
    dut.DM1.Core[62] = {1'b1, cfg_taps};
    dut.DM1.Core[63] = {1'b1, cfg_seed};
    for (int k = 64; k < 128; k++) dut.DM1.Core[k] = fill_out;
    compute_model();
  endtask

  // Cipher computed directly from the rules with integer arithmetic.
  task automatic compute_model();
    int s;
    int p;
    int c;
    s = int'(cfg_seed);
    for (int i = 0; i < 64; i++) begin
      if (i >= int'(cfg_pre) && (i - int'(cfg_pre)) <= 60)
        p = (int'(msg[i - int'(cfg_pre)]) - 32) & 255;
      else
        p = 0;
      c = (p & 127) ^ s;
      if (($countones(c) % 2) == 1) c = c + 128;
      expect_out[i] = 8'(c);
      s = ((s << 1) & 127) | ($countones(s & int'(cfg_taps)) & 1);
    end
  endtask

  task automatic run_engine(input string name);
    int ack_edge;
    ack_edge = 0;
    @(negedge clk);
    ctl.Start = 1'b0;
    for (int e = 1; e <= 100 && ack_edge == 0; e++) begin
      @(posedge clk);
      #1;
      if (ctl.Ack === 1'b1) ack_edge = e;
    end
    check({name, "_ack_edge"}, ack_edge, 68);
    @(negedge clk);
    ctl.Start = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_ack_drop"}, ctl.Ack, 1'b0);
  endtask

  task automatic check_output(input string name, input int first, input int last);
    for (int k = first; k <= last; k++)
      check($sformatf("%s_byte%0d", name, k), dut.DM1.Core[64 + k], expect_out[k]);
  endtask

  task automatic check_input_kept(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k <= 60; k++) if (dut.DM1.Core[k] !== msg[k]) bad++;
    if (dut.DM1.Core[61] !== cfg_pre) bad++;
    if (dut.DM1.Core[62] !== {1'b1, cfg_taps}) bad++;
    if (dut.DM1.Core[63] !== {1'b1, cfg_seed}) bad++;
    check({name, "_input_kept"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [6:0] sweep_taps [0:7];
  logic [7:0] pre_r;
  logic [6:0] seed_r;
  int         untouched_bad;

  initial begin
    vecs[0]  = '{0, 8'd10, 7'h60, 7'h01, 0,  8'h81};
    vecs[1]  = '{0, 8'd10, 7'h60, 7'h01, 1,  8'h82};
    vecs[2]  = '{0, 8'd10, 7'h60, 7'h01, 2,  8'h84};
    vecs[3]  = '{0, 8'd10, 7'h60, 7'h01, 3,  8'h88};
    vecs[4]  = '{0, 8'd10, 7'h60, 7'h01, 4,  8'h90};
    vecs[5]  = '{0, 8'd10, 7'h60, 7'h01, 5,  8'hA0};
    vecs[6]  = '{0, 8'd10, 7'h60, 7'h01, 6,  8'h41};
    vecs[7]  = '{0, 8'd10, 7'h60, 7'h01, 7,  8'h03};
    vecs[8]  = '{0, 8'd10, 7'h60, 7'h01, 8,  8'h06};
    vecs[9]  = '{1, 8'd10, 7'h60, 7'h01, 9,  8'h0C};
    vecs[10] = '{1, 8'd10, 7'h60, 7'h01, 10, 8'h39};
    sweep_taps = '{7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    ctl.Start = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ctl.Ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int v = 0; v <= 10; v++) begin
      apply_stimulus(vecs[v].kind, vecs[v].pre, vecs[v].taps, vecs[v].seed, 8'($urandom));
      run_engine($sformatf("vec%0d", v));
      check($sformatf("vec%0d_spot%0d", v, vecs[v].idx), dut.DM1.Core[64 + vecs[v].idx], vecs[v].want);
      check_output($sformatf("vec%0d", v), 0, 63);
      check_input_kept($sformatf("vec%0d", v));
    end

    $display("[TB] Start held high");
    apply_stimulus(2, 8'd12, 7'h60, 7'h11, 8'h5A);
    repeat (200) @(posedge clk);
    #1;
    check("hold_ack", ctl.Ack, 1'b0);
    untouched_bad = 0;
    for (int k = 64; k < 128; k++) if (dut.DM1.Core[k] !== 8'h5A) untouched_bad++;
    check("hold_untouched", untouched_bad, 0);

    $display("[TB] reset mid-run");
    apply_stimulus(2, 8'd11, 7'h72, 7'h2B, 8'hEE);
    @(negedge clk);
    ctl.Start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ctl.Start = 1'b1;
    #1;
    check("midreset_ack", ctl.Ack, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_output("midreset_written", 0, 24);
    untouched_bad = 0;
    for (int k = 25; k < 64; k++) if (dut.DM1.Core[64 + k] !== 8'hEE) untouched_bad++;
    check("midreset_untouched", untouched_bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_engine("after_reset");
    check_output("after_reset", 0, 63);

    $display("[TB] tap sweep");
    for (int t = 0; t < 8; t++) begin
      pre_r  = 8'($urandom_range(10, 15));
      seed_r = 7'($urandom_range(1, 127));
      apply_stimulus(2, pre_r, sweep_taps[t], seed_r, 8'($urandom));
      run_engine($sformatf("sweep%0d", t));
      check_output($sformatf("sweep%0d", t), 0, 63);
    end

    $display("[TB] full-byte preamble and zero seed");
    apply_stimulus(2, 8'd0, 7'h60, 7'h35, 8'h00);
    run_engine("pre0");
    check_output("pre0", 0, 63);
    apply_stimulus(2, 8'd200, 7'h5C, 7'h09, 8'h00);
    run_engine("pre200");
    check_output("pre200", 0, 63);
    apply_stimulus(2, 8'd13, 7'h7B, 7'h00, 8'hFF);
    run_engine("seed0");
    check_output("seed0", 0, 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
